// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial frame deserializer.
//   state_e       : frame controller FSM states
//   DefaultLength : default number of data bits per word
//   even_parity   : even-parity bit over a data word (zero-extended to 64 bits)
package deser_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam int unsigned DefaultLength = 24;

  // Zero extension does not change the parity, so one fixed-width helper serves any
  // LENGTH up to 64.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// LSB-first serial-to-parallel shift register.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_shift      : shift i_din in at the MSB end (earlier bits move towards the LSB)
//   i_clr        : synchronous clear; combined with i_shift the bit lands in a cleared register
//   i_din        : serial data bit
//   o_word_nxt   : register contents after the current edge
// o_word_nxt exposes the next-state value so the controller can capture a completed word on
// the same edge that shifts in its last bit.
module deser_shift_reg
  import deser_pkg::*;
#(
  parameter int unsigned LENGTH = DefaultLength
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_shift,
  input  logic              i_clr,
  input  logic              i_din,
  output logic [LENGTH-1:0] o_word_nxt
);

  logic [LENGTH-1:0] sr_q;
  logic [LENGTH-1:0] sr_d;
  logic [LENGTH-1:0] base;

  always_comb begin
    base = i_clr ? '0 : sr_q;
    sr_d = base;
    if (i_shift) begin
      sr_d = {i_din, base[LENGTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign o_word_nxt = sr_d;

endmodule

// File: rtl/deser_frame_ctrl.sv
// Frame controller for framed LSB-first serial samples feeding the FIR core.
// Qualifies bits, counts them, captures each completed word into a holding register and
// offers it over valid/ready. The serial side is never backpressured: a word completing while
// the previous one is still waiting is dropped and flagged as an overrun.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_en              : global enable; low freezes the serial side, handshake keeps running
//   i_bit_valid       : qualifies i_din / i_sync
//   i_sync            : first bit of a frame
//   i_din             : serial data bit
//   i_ready           : FIR core accepts ov_word
//   i_clr_err         : clears sticky error flags (a simultaneous error event wins)
//   ov_word, o_valid  : held word and its valid flag
//   o_busy            : frame in progress
//   o_overrun         : sticky, completed word dropped while output was stalled
//   o_frame_err       : sticky, sync seen mid-frame
//   o_parity_err      : sticky, parity mismatch (tied 0 unless DESER_PARITY_EN)
//   ov_bit_cnt        : bits received in the current frame
// Build option: define DESER_PARITY_EN to append an even-parity bit to every frame.
module deser_frame_ctrl
  import deser_pkg::*;
#(
  parameter int unsigned LENGTH = DefaultLength,
`ifdef DESER_PARITY_EN
  parameter int unsigned CNT_W  = $clog2(LENGTH + 2)
`else
  parameter int unsigned CNT_W  = $clog2(LENGTH + 1)
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bit_valid,
  input  logic              i_sync,
  input  logic              i_din,
  input  logic              i_ready,
  input  logic              i_clr_err,
  output logic [LENGTH-1:0] ov_word,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic [CNT_W-1:0]  ov_bit_cnt
);

`ifdef DESER_PARITY_EN
  localparam int unsigned FrameLen = LENGTH + 1;
`else
  localparam int unsigned FrameLen = LENGTH;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LENGTH-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              bit_acc;
  logic              sr_shift;
  logic              sr_clr;
  logic [LENGTH-1:0] sr_word_nxt;
  logic              complete;
  logic              resync;
  logic              par_ok;

  assign bit_acc = i_en & i_bit_valid;

  deser_shift_reg #(
    .LENGTH(LENGTH)
  ) u_shift (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_shift    (sr_shift),
    .i_clr      (sr_clr),
    .i_din      (i_din),
    .o_word_nxt (sr_word_nxt)
  );

  // Frame sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_shift = 1'b0;
    sr_clr   = 1'b0;
    complete = 1'b0;
    resync   = 1'b0;
    if (bit_acc) begin
      case (state_q)
        StIdle: begin
          if (i_sync) begin
            state_d  = StShift;
            cnt_d    = CNT_W'(1);
            sr_clr   = 1'b1;
            sr_shift = 1'b1;
          end
        end
        StShift: begin
          if (i_sync) begin
            // Drop the partial frame; this bit becomes bit 0 of a fresh one.
            resync   = 1'b1;
            cnt_d    = CNT_W'(1);
            sr_clr   = 1'b1;
            sr_shift = 1'b1;
          end else if (cnt_q == CNT_W'(FrameLen - 1)) begin
            complete = 1'b1;
            state_d  = StIdle;
            cnt_d    = '0;
`ifdef DESER_PARITY_EN
            sr_shift = 1'b0;  // parity bit is checked, not stored
`else
            sr_shift = 1'b1;
`endif
          end else begin
            cnt_d    = cnt_q + 1'b1;
            sr_shift = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef DESER_PARITY_EN
  logic parity_err_q, parity_err_d;

  assign par_ok = (even_parity(64'(sr_word_nxt)) == i_din);

  always_comb begin
    parity_err_d = (parity_err_q & ~i_clr_err) | (complete & ~par_ok);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign o_parity_err = parity_err_q;
`else
  assign par_ok       = 1'b1;
  assign o_parity_err = 1'b0;
`endif

  // Output holding register, handshake and sticky flags.
  always_comb begin
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q & ~i_clr_err;
    frame_err_d = (frame_err_q & ~i_clr_err) | resync;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (complete && par_ok) begin
      if (valid_q && !i_ready) begin
        overrun_d = 1'b1;
      end else begin
        // Covers the transfer-and-reload case: valid stays high with the new word.
        word_d  = sr_word_nxt;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ov_word     = word_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q == StShift);
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;
  assign ov_bit_cnt  = cnt_q;

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Directed self-checking bench for deser_frame_ctrl (LENGTH = 24).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_deser_frame_ctrl;

  localparam int unsigned LEN = 24;
`ifdef DESER_PARITY_EN
  localparam int unsigned FRAME_LEN = LEN + 1;
  localparam int unsigned CW = $clog2(LEN + 2);
`else
  localparam int unsigned FRAME_LEN = LEN;
  localparam int unsigned CW = $clog2(LEN + 1);
`endif

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_en = 1'b1;
  logic           i_bit_valid = 1'b0;
  logic           i_sync = 1'b0;
  logic           i_din = 1'b0;
  logic           i_ready = 1'b0;
  logic           i_clr_err = 1'b0;
  logic [LEN-1:0] ov_word;
  logic           o_valid;
  logic           o_busy;
  logic           o_overrun;
  logic           o_frame_err;
  logic           o_parity_err;
  logic [CW-1:0]  ov_bit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  deser_frame_ctrl #(
    .LENGTH(LEN),
    .CNT_W (CW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_bit_valid (i_bit_valid),
    .i_sync      (i_sync),
    .i_din       (i_din),
    .i_ready     (i_ready),
    .i_clr_err   (i_clr_err),
    .ov_word     (ov_word),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .ov_bit_cnt  (ov_bit_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Bit i of a frame: data LSB-first, then (with parity) the even-parity bit.
  function automatic logic frame_bit(input logic [LEN-1:0] w, input int i);
    if (i < int'(LEN)) return w[i];
    return ^w;
  endfunction

  task automatic drive_bit(input logic s, input logic d);
    @(negedge i_clk);
    i_bit_valid = 1'b1;
    i_sync      = s;
    i_din       = d;
  endtask

  task automatic idle_cycle();
    @(negedge i_clk);
    i_bit_valid = 1'b0;
    i_sync      = 1'b0;
    i_din       = 1'b0;
  endtask

  task automatic send_frame(input logic [LEN-1:0] w);
    for (int i = 0; i < int'(FRAME_LEN); i++) drive_bit(i == 0, frame_bit(w, i));
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_cmp++; if (ov_word !== '0) begin n_err++; $display("FAIL reset_word: got %h want 0", ov_word); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", o_frame_err); end
    n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL reset_parity_err: got %b want 0", o_parity_err); end
    n_cmp++; if (ov_bit_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", ov_bit_cnt); end
    i_rst = 1'b0;
  endtask

  task automatic test_word_load();
    logic [LEN-1:0] w = 24'hA5C3F1;
    i_ready = 1'b1;
    for (int i = 0; i < int'(FRAME_LEN); i++) drive_bit(i == 0, frame_bit(w, i));
    // Last bit is driven but not yet sampled.
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL load_early_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b want 1", o_busy); end
    n_cmp++; if (ov_bit_cnt !== CW'(FRAME_LEN - 1)) begin n_err++; $display("FAIL load_cnt: got %0d want %0d", ov_bit_cnt, FRAME_LEN - 1); end
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b want 1", o_valid); end
    n_cmp++; if (ov_word !== 24'hA5C3F1) begin n_err++; $display("FAIL load_word: got %h want a5c3f1", ov_word); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL load_busy_done: got %b want 0", o_busy); end
    n_cmp++; if (ov_bit_cnt !== '0) begin n_err++; $display("FAIL load_cnt_done: got %0d want 0", ov_bit_cnt); end
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL load_valid_clear: got %b want 0", o_valid); end
  endtask

  task automatic test_overrun();
    i_ready = 1'b0;
    send_frame(24'h123456);
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ovr_first_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first_flag: got %b want 0", o_overrun); end
    send_frame(24'h654321);
    idle_cycle();
    n_cmp++; if (ov_word !== 24'h123456) begin n_err++; $display("FAIL ovr_word_held: got %h want 123456", ov_word); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held: got %b want 1", o_valid); end
    n_cmp++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", o_overrun); end
    i_ready = 1'b1;
    @(negedge i_clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ovr_transfer: got %b want 0", o_valid); end
    n_cmp++; if (o_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
    i_clr_err = 1'b1;
    @(negedge i_clk);
    i_clr_err = 1'b0;
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", o_overrun); end
  endtask

  task automatic test_resync();
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive_bit(i == 0, 1'b1);
    send_frame(24'h0F0F0F);
    idle_cycle();
    n_cmp++; if (o_frame_err !== 1'b1) begin n_err++; $display("FAIL resync_err: got %b want 1", o_frame_err); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL resync_valid: got %b want 1", o_valid); end
    n_cmp++; if (ov_word !== 24'h0F0F0F) begin n_err++; $display("FAIL resync_word: got %h want 0f0f0f", ov_word); end
    i_clr_err = 1'b1;
    idle_cycle();
    i_clr_err = 1'b0;
    n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL resync_clear: got %b want 0", o_frame_err); end
    for (int i = 0; i < int'(FRAME_LEN); i++) drive_bit(1'b0, 1'b1);
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL nosync_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL nosync_busy: got %b want 0", o_busy); end
    n_cmp++; if (ov_bit_cnt !== '0) begin n_err++; $display("FAIL nosync_cnt: got %0d want 0", ov_bit_cnt); end
  endtask

  task automatic test_enable_freeze();
    logic [LEN-1:0] w = 24'hDEADBE;
    logic [LEN-1:0] w2 = 24'hABCDEF;
    i_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive_bit(i == 0, w[i]);
    // Garbage, including a sync, while disabled.
    for (int k = 0; k < 5; k++) begin
      drive_bit(1'b1, ~frame_bit(w, 10));
      i_en = 1'b0;
    end
    n_cmp++; if (ov_bit_cnt !== CW'(10)) begin n_err++; $display("FAIL freeze_cnt: got %0d want 10", ov_bit_cnt); end
    n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL freeze_busy: got %b want 1", o_busy); end
    for (int i = 10; i < int'(FRAME_LEN); i++) begin
      drive_bit(1'b0, frame_bit(w, i));
      i_en = 1'b1;
    end
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL freeze_valid: got %b want 1", o_valid); end
    n_cmp++; if (ov_word !== 24'hDEADBE) begin n_err++; $display("FAIL freeze_word: got %h want deadbe", ov_word); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_err++; $display("FAIL freeze_frame_err: got %b want 0", o_frame_err); end
    // Handshake still runs with the serial side disabled.
    i_en    = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL freeze_handshake: got %b want 0", o_valid); end
    i_en    = 1'b1;
    i_ready = 1'b0;
    // Reset at bit 12 of the next frame.
    for (int i = 0; i < 12; i++) drive_bit(i == 0, w2[i]);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    n_cmp++; if (ov_word !== '0) begin n_err++; $display("FAIL rst_word: got %h want 0", ov_word); end
    n_cmp++; if (ov_bit_cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", ov_bit_cnt); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 12; i < int'(FRAME_LEN); i++) drive_bit(1'b0, frame_bit(w2, i));
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_word: got %b want 0", o_valid); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_idle: got %b want 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    logic [LEN-1:0] w2 = 24'h222222;
    i_ready = 1'b0;
    send_frame(24'h111111);
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      drive_bit(i == 0, frame_bit(w2, i));
      if (i == int'(FRAME_LEN) - 1) begin
        // Transfer of the first word coincides with completion of the second.
        i_ready = 1'b1;
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid: got %b want 1", o_valid); end
        n_cmp++; if (ov_word !== 24'h111111) begin n_err++; $display("FAIL b2b_first_word: got %h want 111111", ov_word); end
      end
    end
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_held: got %b want 1", o_valid); end
    n_cmp++; if (ov_word !== 24'h222222) begin n_err++; $display("FAIL b2b_second_word: got %h want 222222", ov_word); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", o_overrun); end
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_clear: got %b want 0", o_valid); end
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    logic [LEN-1:0] w = 24'h000001;
    i_ready = 1'b1;
    send_frame(w);
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL par_good_valid: got %b want 1", o_valid); end
    n_cmp++; if (ov_word !== 24'h000001) begin n_err++; $display("FAIL par_good_word: got %h want 000001", ov_word); end
    n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL par_good_flag: got %b want 0", o_parity_err); end
    idle_cycle();
    for (int i = 0; i < int'(LEN); i++) drive_bit(i == 0, w[i]);
    drive_bit(1'b0, 1'b0);
    idle_cycle();
    n_cmp++; if (o_parity_err !== 1'b1) begin n_err++; $display("FAIL par_bad_flag: got %b want 1", o_parity_err); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL par_bad_valid: got %b want 0", o_valid); end
  endtask
`else
  task automatic test_parity();
    i_ready = 1'b1;
    send_frame(24'hFFFFFE);
    idle_cycle();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL nopar_valid: got %b want 1", o_valid); end
    n_cmp++; if (ov_word !== 24'hFFFFFE) begin n_err++; $display("FAIL nopar_word: got %h want fffffe", ov_word); end
    n_cmp++; if (o_parity_err !== 1'b0) begin n_err++; $display("FAIL nopar_flag: got %b want 0", o_parity_err); end
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_overrun();
    test_resync();
    test_enable_freeze();
    test_back_to_back();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
